branch_unit: RTL and testbench

Sequencer for the branch comparator in the execute stage. Accepts one branch request at a time from issue via a valid/ready handshake and registers its operands. It evaluates the condition through one `cmp` instance, reports the outcome, and drives a held redirect toward fetch until fetch acknowledges it. It also keeps saturating branch and redirect counters for performance monitoring.

---
 rtl/cmp_pkg.sv | 21 ++
 rtl/cmp.sv | 27 ++
 rtl/branch_unit.sv | 154 +++++++++++++++
 tb/tb_branch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared comparator package.
// Holds the branch condition encoding, the branch sequencer state encoding and
// the sequential-PC increment. Imported by cmp, branch_unit and the bench.
package cmp_pkg;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    BEQ = 2'd1,
    BLT = 2'd2,
    BLE = 2'd3
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2
  } branch_state_e;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/cmp.sv
// Combinational branch condition comparator.
// Ports:
//   i_op    : condition (NOP/BEQ/BLT/BLE)
//   i_a,i_b : operands, compared unsigned
//   o_taken : condition result; always 0 for NOP
module cmp
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  cmp_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_op)
      BEQ:     o_taken = (i_a == i_b);
      BLT:     o_taken = (i_a <  i_b);
      BLE:     o_taken = (i_a <= i_b);
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch sequencer for the execute stage.
// Accepts one branch at a time, evaluates it through a cmp instance, reports the
// outcome for one cycle and holds a redirect toward fetch until acknowledged.
// Keeps saturating performance counters for branches and redirects.
//
// Handshake: a request transfers on a rising edge where i_valid && o_ready.
// o_ready is high only in IDLE and only while i_flush is low; i_valid may be
// held across cycles and the request fields must be stable while i_valid is high.
// The redirect is a held request: o_redirect/o_redirect_pc stay stable until the
// edge where i_redirect_ack (or i_flush) is seen.
//
// Build option: define BRANCH_PRED_EN for static BTFN prediction, in which
// case only mispredicted branches redirect (to pc+offset or pc+4). Without it,
// fetch assumes not-taken and every taken branch redirects to pc+offset.
//
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_valid/o_ready         : request handshake
//   i_op,i_rs1,i_rs2        : condition and operands
//   i_pc,i_offset           : branch PC and signed byte offset
//   i_flush                 : pipeline kill
//   o_done,o_taken          : one-cycle outcome pulse
//   o_redirect,o_redirect_pc: held redirect toward fetch, i_redirect_ack accepts it
//   o_branch_cnt            : completed non-NOP branches (saturating)
//   o_redirect_cnt          : redirects issued (saturating)
//   o_state                 : FSM state, for debug
module branch_unit
  import cmp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  cmp_op_e               i_op,
  input  logic [DATA_WIDTH-1:0] i_rs1,
  input  logic [DATA_WIDTH-1:0] i_rs2,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [ADDR_WIDTH-1:0] i_offset,
  input  logic                  i_flush,
  output logic                  o_done,
  output logic                  o_taken,
  output logic                  o_redirect,
  output logic [ADDR_WIDTH-1:0] o_redirect_pc,
  input  logic                  i_redirect_ack,
  output logic [CNT_WIDTH-1:0]  o_branch_cnt,
  output logic [CNT_WIDTH-1:0]  o_redirect_cnt,
  output branch_state_e         o_state
);

  branch_state_e         state;
  cmp_op_e               op_q;
  logic [DATA_WIDTH-1:0] rs1_q;
  logic [DATA_WIDTH-1:0] rs2_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] off_q;

  logic                  cmp_taken;
  logic [ADDR_WIDTH-1:0] taken_target;
  logic [ADDR_WIDTH-1:0] fall_target;
  logic                  need_redirect;
  logic [ADDR_WIDTH-1:0] redirect_target;

  cmp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .i_op   (op_q),
    .i_a    (rs1_q),
    .i_b    (rs2_q),
    .o_taken(cmp_taken)
  );

  // Both targets wrap silently modulo 2^ADDR_WIDTH.
  assign taken_target = pc_q + off_q;
  assign fall_target  = pc_q + ADDR_WIDTH'(PC_INCR);

`ifdef BRANCH_PRED_EN
  // Fetch already followed the BTFN guess (backward = taken); only a
  // disagreement between the guess and the real outcome needs a redirect.
  assign need_redirect   = (op_q != NOP) && (cmp_taken != off_q[ADDR_WIDTH-1]);
  assign redirect_target = cmp_taken ? taken_target : fall_target;
`else
  // Fetch always falls through, so every taken branch redirects.
  assign need_redirect   = cmp_taken;
  assign redirect_target = taken_target;
`endif

  assign o_ready = (state == IDLE) && !i_flush;
  // A flush in EVAL kills the outcome in the same cycle.
  assign o_done  = (state == EVAL) && !i_flush;
  assign o_taken = o_done && cmp_taken;
  assign o_state = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      op_q           <= NOP;
      rs1_q          <= '0;
      rs2_q          <= '0;
      pc_q           <= '0;
      off_q          <= '0;
      o_redirect     <= 1'b0;
      o_redirect_pc  <= '0;
      o_branch_cnt   <= '0;
      o_redirect_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            op_q  <= i_op;
            rs1_q <= i_rs1;
            rs2_q <= i_rs2;
            pc_q  <= i_pc;
            off_q <= i_offset;
            state <= EVAL;
          end
        end
        EVAL: begin
          if (i_flush) begin
            state <= IDLE;
          end else begin
            if ((op_q != NOP) && (o_branch_cnt != '1)) begin
              o_branch_cnt <= o_branch_cnt + 1'b1;
            end
            if (need_redirect) begin
              o_redirect    <= 1'b1;
              o_redirect_pc <= redirect_target;
              if (o_redirect_cnt != '1) begin
                o_redirect_cnt <= o_redirect_cnt + 1'b1;
              end
              state <= REDIRECT;
            end else begin
              state <= IDLE;
            end
          end
        end
        REDIRECT: begin
          if (i_redirect_ack || i_flush) begin
            o_redirect <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          o_redirect <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit. A second instance with 4-bit counters shares all
// inputs so counter saturation is reached within a short run.
module tb_branch_unit;
  import cmp_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  cmp_op_e       i_op = NOP;
  logic [31:0]   i_rs1 = '0, i_rs2 = '0, i_pc = '0, i_offset = '0;
  logic          i_flush = 1'b0;
  logic          i_redirect_ack = 1'b0;

  logic          o_ready, o_done, o_taken, o_redirect;
  logic [31:0]   o_redirect_pc, o_branch_cnt, o_redirect_cnt;
  branch_state_e o_state;

  logic          s_ready, s_done, s_taken, s_redirect;
  logic [31:0]   s_redirect_pc;
  logic [3:0]    s_branch_cnt, s_redirect_cnt;
  branch_state_e s_state;

  int checks = 0;
  int errors = 0;

  // Expected counter values and pending redirect targets.
  logic [31:0] exp_branch_cnt, exp_redirect_cnt;
  logic [3:0]  exp_small_b, exp_small_r;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  branch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_pc(i_pc), .i_offset(i_offset),
    .i_flush(i_flush), .o_done(o_done), .o_taken(o_taken),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .i_redirect_ack(i_redirect_ack), .o_branch_cnt(o_branch_cnt),
    .o_redirect_cnt(o_redirect_cnt), .o_state(o_state)
  );

  branch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(4)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(s_ready),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_pc(i_pc), .i_offset(i_offset),
    .i_flush(i_flush), .o_done(s_done), .o_taken(s_taken),
    .o_redirect(s_redirect), .o_redirect_pc(s_redirect_pc),
    .i_redirect_ack(i_redirect_ack), .o_branch_cnt(s_branch_cnt),
    .o_redirect_cnt(s_redirect_cnt), .o_state(s_state)
  );

  // Reference: branch outcome from the condition definition (unsigned compare).
  function automatic bit model_taken(cmp_op_e op, logic [31:0] a, logic [31:0] b);
    if (op == BEQ) return a == b;
    if (op == BLT) return a < b;
    if (op == BLE) return (a < b) || (a == b);
    return 1'b0;
  endfunction

  function automatic logic [31:0] sat32(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [3:0] sat4(logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Driver: runs one request from IDLE back to IDLE, checking every cycle.
  // Called at a negedge with the unit idle.
  task automatic do_branch(input cmp_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] off,
                           input bit flush_eval, input bit flush_redir, input int ack_delay);
    bit          tk, rd;
    logic [31:0] tgt, exp_t;
    tk = model_taken(op, a, b);
`ifdef BRANCH_PRED_EN
    rd  = (op != NOP) && (tk != off[31]);
    tgt = tk ? pc + off : pc + 32'd4;
`else
    rd  = tk;
    tgt = pc + off;
`endif
    i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_pc = pc; i_offset = off; i_flush = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_accept got %0b exp 1", o_ready); end
    @(negedge clk);
    // Scramble the request fields to prove the operands were latched.
    i_valid = 1'b0; i_op = cmp_op_e'($urandom_range(0, 3));
    i_rs1 = $urandom; i_rs2 = $urandom; i_pc = $urandom; i_offset = $urandom;
    i_flush = flush_eval;
    #1;
    checks++; if (o_done !== !flush_eval) begin errors++; $display("FAIL done got %0b exp %0b", o_done, !flush_eval); end
    checks++; if (o_taken !== (tk && !flush_eval)) begin errors++; $display("FAIL taken got %0b exp %0b", o_taken, tk && !flush_eval); end
    checks++; if (o_ready !== 1'b0 || o_redirect !== 1'b0) begin errors++; $display("FAIL eval_busy got ready %0b redirect %0b exp 0 0", o_ready, o_redirect); end
    @(negedge clk);
    i_flush = 1'b0;
    if (!flush_eval) begin
      if (op != NOP) begin exp_branch_cnt = sat32(exp_branch_cnt); exp_small_b = sat4(exp_small_b); end
      if (rd) begin exp_redirect_cnt = sat32(exp_redirect_cnt); exp_small_r = sat4(exp_small_r); exp_q.push_back(tgt); end
    end
    checks++; if (o_branch_cnt !== exp_branch_cnt) begin errors++; $display("FAIL branch_cnt got %0h exp %0h", o_branch_cnt, exp_branch_cnt); end
    checks++; if (o_redirect_cnt !== exp_redirect_cnt) begin errors++; $display("FAIL redirect_cnt got %0h exp %0h", o_redirect_cnt, exp_redirect_cnt); end
    checks++; if (s_branch_cnt !== exp_small_b || s_redirect_cnt !== exp_small_r) begin
      errors++; $display("FAIL small_cnt got %0h/%0h exp %0h/%0h", s_branch_cnt, s_redirect_cnt, exp_small_b, exp_small_r); end
    if (exp_q.size() != 0) begin
      exp_t = exp_q.pop_front();
      for (int i = 0; i <= ack_delay; i++) begin
        checks++; if (o_redirect !== 1'b1) begin errors++; $display("FAIL redirect_held got %0b exp 1", o_redirect); end
        checks++; if (o_redirect_pc !== exp_t) begin errors++; $display("FAIL redirect_pc got %0h exp %0h", o_redirect_pc, exp_t); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL ready_redirect got %0b exp 0", o_ready); end
        if (i == ack_delay) begin
          if (flush_redir) begin i_flush = 1'b1; i_redirect_ack = 1'($urandom_range(0, 1)); end
          else i_redirect_ack = 1'b1;
        end
        @(negedge clk);
      end
      i_flush = 1'b0; i_redirect_ack = 1'b0;
    end
    #1;
    checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL redirect_drop got %0b exp 0", o_redirect); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_back got %0b exp 1", o_ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (o_ready !== 1'b1 || o_done !== 1'b0 || o_taken !== 1'b0 || o_redirect !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got ready %0b done %0b taken %0b redir %0b exp 1 0 0 0", o_ready, o_done, o_taken, o_redirect); end
    checks++; if (o_redirect_pc !== 32'h0 || o_branch_cnt !== 32'h0 || o_redirect_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_regs got %0h %0h %0h exp 0 0 0", o_redirect_pc, o_branch_cnt, o_redirect_cnt); end
    checks++; if (o_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", o_state, IDLE); end
    rst = 1'b0;
    exp_branch_cnt = '0; exp_redirect_cnt = '0; exp_small_b = '0; exp_small_r = '0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_branch(BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b0, 2);
    do_branch(BLT, 32'hFFFF_FFFF, 32'd1, 32'h140, 32'h40, 1'b0, 1'b0, 0);
    do_branch(BLE, 32'd3, 32'd3, 32'h200, 32'hFFFF_FFF8, 1'b0, 1'b0, 1);
    do_branch(BLE, 32'd4, 32'd3, 32'h200, 32'hFFFF_FFF8, 1'b0, 1'b0, 0);
    do_branch(BLT, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'h10, 1'b0, 1'b0, 0);
  endtask

  task automatic test_flush();
    do_branch(BEQ, 32'd9, 32'd9, 32'h400, 32'h8, 1'b1, 1'b0, 0);
    do_branch(BEQ, 32'd9, 32'd9, 32'h400, 32'h8, 1'b0, 1'b1, 1);
    do_branch(BLT, 32'd1, 32'd2, 32'h480, 32'hFFFF_FF00, 1'b0, 1'b1, 0);
  endtask

  task automatic test_wrap();
    do_branch(BEQ, 32'hABCD, 32'hABCD, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0, 0);
    do_branch(BLE, 32'd7, 32'd2, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_nop_and_idle_flush();
    do_branch(NOP, 32'd1, 32'd1, 32'h500, 32'h40, 1'b0, 1'b0, 0);
    do_branch(NOP, 32'd1, 32'd2, 32'h500, 32'hFFFF_FFC0, 1'b0, 1'b0, 0);
    // Held request under flush must not be taken.
    i_valid = 1'b1; i_op = BEQ; i_rs1 = 32'd1; i_rs2 = 32'd1; i_flush = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL ready_flush got %0b exp 0", o_ready); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (o_done !== 1'b0 || o_state !== IDLE) begin errors++; $display("FAIL flush_idle got done %0b state %0d exp 0 %0d", o_done, o_state, IDLE); end
    checks++; if (o_branch_cnt !== exp_branch_cnt) begin errors++; $display("FAIL flush_idle_cnt got %0h exp %0h", o_branch_cnt, exp_branch_cnt); end
    i_valid = 1'b0; i_flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    do_branch(BEQ, 32'd3, 32'd3, 32'h600, 32'h4, 1'b0, 1'b0, 0);
    i_valid = 1'b1; i_op = BEQ; i_rs1 = 32'd2; i_rs2 = 32'd2; i_pc = 32'h700; i_offset = 32'h10;
    @(negedge clk);
    i_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_branch_cnt = '0; exp_redirect_cnt = '0; exp_small_b = '0; exp_small_r = '0;
    #1;
    checks++; if (o_redirect !== 1'b0 || o_ready !== 1'b1 || o_done !== 1'b0) begin
      errors++; $display("FAIL midop_reset got redir %0b ready %0b done %0b exp 0 1 0", o_redirect, o_ready, o_done); end
    checks++; if (o_branch_cnt !== 32'h0 || o_redirect_cnt !== 32'h0) begin
      errors++; $display("FAIL midop_cnt got %0h %0h exp 0 0", o_branch_cnt, o_redirect_cnt); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom);
      do_branch(cmp_op_e'($urandom_range(0, 3)), a, b, $urandom, $urandom,
                $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3));
    end
  endtask

  task automatic test_saturation();
    // Keep issuing taken, redirecting branches until both small counters peg.
    for (int n = 0; n < 20; n++) begin
`ifdef BRANCH_PRED_EN
      do_branch(BEQ, 32'd1, 32'd1, 32'h800, 32'h40, 1'b0, 1'b0, 0);
`else
      do_branch(BLE, 32'd1, 32'd2, 32'h800, 32'h40, 1'b0, 1'b0, 0);
`endif
    end
    checks++; if (s_branch_cnt !== 4'hF || s_redirect_cnt !== 4'hF) begin
      errors++; $display("FAIL saturate got %0h/%0h exp f/f", s_branch_cnt, s_redirect_cnt); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_wrap();
    test_nop_and_idle_flush();
    test_reset_midop();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
